ctrl_unit: RTL and testbench

- Main decoder/controller of the single-issue RV32I core.
- Takes opcode (inst[6:2]), func3, func7 and the branch-compare result `b`, and drives every datapath select: immediate mux, ALU, comparator, operand muxes, rd mux, PC/memory-address select, instruction management, register-file write and data-memory write.
- Purely combinational except a one-bit load-phase register that splits LOAD into two cycles.

---
 rtl/ctrl_pkg.sv | 63 ++++++
 rtl/ctrl_alu_dec.sv | 35 +++
 rtl/ctrl_unit.sv | 139 +++++++++++++
 tb/tb_ctrl_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the RV32I controller: opcodes, funct fields and datapath select codes.
package ctrl_pkg;

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_OP_IMM = 5'b00100;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_OP     = 5'b01100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_JAL    = 5'b11011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_WORD    = 3'b010;

    // func7 value that selects SUB / SRA variants
    localparam logic [6:0] F7_ALT = 7'b0100000;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_XOR  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic [2:0] IMM_NONE = 3'b000;
    localparam logic [2:0] IMM_U    = 3'b001;
    localparam logic [2:0] IMM_J    = 3'b010;
    localparam logic [2:0] IMM_S    = 3'b011;
    localparam logic [2:0] IMM_I    = 3'b100;
    localparam logic [2:0] IMM_B    = 3'b101;

    localparam logic [1:0] RD_ALU = 2'b00;
    localparam logic [1:0] RD_MEM = 2'b01;
    localparam logic [1:0] RD_PC4 = 2'b10;
    localparam logic [1:0] RD_IMM = 2'b11;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_TARGET = 2'b01;
    localparam logic [1:0] PC_HOLD   = 2'b10;

    localparam logic [1:0] INST_PASS = 2'b00;
    localparam logic [1:0] INST_NOP  = 2'b01;
    localparam logic [1:0] INST_HOLD = 2'b10;

    typedef enum logic {
        PH_ADDR = 1'b0,
        PH_WB   = 1'b1
    } load_phase_t;

endpackage

// File: rtl/ctrl_alu_dec.sv
// ALU operation decode from opcode / func3 / func7.
module ctrl_alu_dec
    import ctrl_pkg::*;
(
    input  logic [4:0] opcode,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    output logic [3:0] alu_op
);

    logic is_arith;
    logic alt;

    assign is_arith = (opcode == OP_OP) || (opcode == OP_OP_IMM);
    assign alt      = (func7 == F7_ALT);

    always_comb begin
        alu_op = ALU_ADD;
        if (is_arith) begin
            case (func3)
                // OP_IMM has no subtract form, so func7 only matters for register OP
                F3_ADD_SUB: alu_op = (opcode == OP_OP && alt) ? ALU_SUB : ALU_ADD;
                F3_SLL:     alu_op = ALU_SLL;
                F3_SLT:     alu_op = ALU_SLT;
                F3_SLTU:    alu_op = ALU_SLTU;
                F3_XOR:     alu_op = ALU_XOR;
                F3_SR:      alu_op = alt ? ALU_SRA : ALU_SRL;
                F3_OR:      alu_op = ALU_OR;
                F3_AND:     alu_op = ALU_AND;
                default:    alu_op = ALU_ADD;
            endcase
        end
    end

endmodule

// File: rtl/ctrl_unit.sv
// Main RV32I decoder/controller; combinational apart from the two-cycle LOAD phase bit.
module ctrl_unit
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] opcode,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       b,
    output logic [2:0] imm_type,
    output logic [1:0] inst_sel,
    output logic       reg_wr,
    output logic [3:0] alu_op,
    output logic [2:0] cmp_op,
    output logic [1:0] pc_sel,
    output logic       mem_sel,
    output logic [1:0] rd_sel,
    output logic       alu1_sel,
    output logic       alu2_sel,
    output logic [2:0] sel_type,
    output logic       we
);

    load_phase_t phase_reg;
    load_phase_t phase_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_reg <= PH_ADDR;
        end else begin
            phase_reg <= phase_next;
        end
    end

    // Back-to-back LOADs keep alternating address / write-back cycles
    always_comb begin
        phase_next = PH_ADDR;
        if (opcode == OP_LOAD) begin
            phase_next = (phase_reg == PH_ADDR) ? PH_WB : PH_ADDR;
        end
    end

    ctrl_alu_dec u_alu_dec (
        .opcode (opcode),
        .func3  (func3),
        .func7  (func7),
        .alu_op (alu_op)
    );

    always_comb begin
        imm_type = IMM_NONE;
        inst_sel = INST_PASS;
        reg_wr   = 1'b0;
        cmp_op   = 3'b000;
        pc_sel   = PC_PLUS4;
        mem_sel  = 1'b0;
        rd_sel   = RD_ALU;
        alu1_sel = 1'b0;
        alu2_sel = 1'b1;
        sel_type = F3_WORD;
        we       = 1'b0;

        case (opcode)
            OP_LOAD: begin
                imm_type = IMM_I;
                sel_type = func3;
                rd_sel   = RD_MEM;
                if (phase_reg == PH_ADDR) begin
                    mem_sel  = 1'b1;
                    pc_sel   = PC_HOLD;
                    inst_sel = INST_HOLD;
                end else begin
                    reg_wr = 1'b1;
                end
            end
            OP_OP_IMM: begin
                imm_type = IMM_I;
                reg_wr   = 1'b1;
            end
            OP_AUIPC: begin
                imm_type = IMM_U;
                alu1_sel = 1'b1;
                reg_wr   = 1'b1;
            end
            OP_STORE: begin
                imm_type = IMM_S;
                sel_type = func3;
                we       = 1'b1;
                mem_sel  = 1'b1;
            end
            OP_OP: begin
                alu2_sel = 1'b0;
                reg_wr   = 1'b1;
            end
            OP_LUI: begin
                imm_type = IMM_U;
                rd_sel   = RD_IMM;
                reg_wr   = 1'b1;
            end
            OP_BRANCH: begin
                imm_type = IMM_B;
                alu1_sel = 1'b1;
                cmp_op   = func3;
                if (b) begin
                    pc_sel   = PC_TARGET;
                    inst_sel = INST_NOP;
                end
            end
            OP_JALR: begin
                imm_type = IMM_I;
                rd_sel   = RD_PC4;
                reg_wr   = 1'b1;
                pc_sel   = PC_TARGET;
                inst_sel = INST_NOP;
            end
            OP_JAL: begin
                imm_type = IMM_J;
                alu1_sel = 1'b1;
                rd_sel   = RD_PC4;
                reg_wr   = 1'b1;
                pc_sel   = PC_TARGET;
                inst_sel = INST_NOP;
            end
            default: begin
            end
        endcase

        // Reset squashes every side effect and keeps the pipeline fed with NOPs
        if (rst) begin
            reg_wr   = 1'b0;
            we       = 1'b0;
            pc_sel   = PC_PLUS4;
            inst_sel = INST_NOP;
            mem_sel  = 1'b0;
        end
    end

endmodule

// File: tb/tb_ctrl_unit.sv
// Self-checking bench for ctrl_unit: directed test-plan cases plus random decode against a reference model.
module tb_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       b;
    logic [2:0] imm_type;
    logic [1:0] inst_sel;
    logic       reg_wr;
    logic [3:0] alu_op;
    logic [2:0] cmp_op;
    logic [1:0] pc_sel;
    logic       mem_sel;
    logic [1:0] rd_sel;
    logic       alu1_sel;
    logic       alu2_sel;
    logic [2:0] sel_type;
    logic       we;

    int n_checks = 0;
    int n_errors = 0;
    int n_txn    = 0;
    int load_run = 0;   // consecutive LOAD cycles since the last non-LOAD or reset

    always #5 clk = ~clk;

    ctrl_unit dut (
        .clk      (clk),
        .rst      (rst),
        .opcode   (opcode),
        .func3    (func3),
        .func7    (func7),
        .b        (b),
        .imm_type (imm_type),
        .inst_sel (inst_sel),
        .reg_wr   (reg_wr),
        .alu_op   (alu_op),
        .cmp_op   (cmp_op),
        .pc_sel   (pc_sel),
        .mem_sel  (mem_sel),
        .rd_sel   (rd_sel),
        .alu1_sel (alu1_sel),
        .alu2_sel (alu2_sel),
        .sel_type (sel_type),
        .we       (we)
    );

    typedef struct {
        logic [2:0] imm_type;
        logic [1:0] inst_sel;
        logic       reg_wr;
        logic [3:0] alu_op;
        logic [2:0] cmp_op;
        logic [1:0] pc_sel;
        logic       mem_sel;
        logic [1:0] rd_sel;
        logic       alu1_sel;
        logic       alu2_sel;
        logic [2:0] sel_type;
        logic       we;
    } exp_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (txn %0d)", tag, obs, exp, n_txn);
        end
    endtask

    // Reference model: each output derived independently from its own rule list
    function automatic exp_t model(input logic [4:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                   input logic bb, input logic r, input logic ph);
        exp_t e;
        bit is_load, is_store, is_op, is_opi, is_lui, is_auipc, is_br, is_jal, is_jalr;
        bit redirect, hold;
        is_load  = (op == 5'd0);
        is_opi   = (op == 5'd4);
        is_auipc = (op == 5'd5);
        is_store = (op == 5'd8);
        is_op    = (op == 5'd12);
        is_lui   = (op == 5'd13);
        is_br    = (op == 5'd24);
        is_jalr  = (op == 5'd25);
        is_jal   = (op == 5'd27);

        e.alu_op = 4'd0;
        if (is_op || is_opi) begin
            case (f3)
                3'd0: e.alu_op = (is_op && f7 == 7'h20) ? 4'd1 : 4'd0;
                3'd1: e.alu_op = 4'd5;
                3'd2: e.alu_op = 4'd8;
                3'd3: e.alu_op = 4'd9;
                3'd4: e.alu_op = 4'd2;
                3'd5: e.alu_op = (f7 == 7'h20) ? 4'd7 : 4'd6;
                3'd6: e.alu_op = 4'd3;
                default: e.alu_op = 4'd4;
            endcase
        end

        e.imm_type = is_lui || is_auipc ? 3'd1 : is_jal ? 3'd2 : is_store ? 3'd3 :
                     (is_opi || is_load || is_jalr) ? 3'd4 : is_br ? 3'd5 : 3'd0;
        e.alu1_sel = is_jal || is_auipc || is_br;
        e.alu2_sel = !is_op;
        e.cmp_op   = is_br ? f3 : 3'd0;
        e.sel_type = (is_load || is_store) ? f3 : 3'd2;
        e.rd_sel   = is_load ? 2'd1 : (is_jal || is_jalr) ? 2'd2 : is_lui ? 2'd3 : 2'd0;

        redirect   = is_jal || is_jalr || (is_br && bb);
        hold       = is_load && !ph;
        e.reg_wr   = is_op || is_opi || is_lui || is_auipc || is_jal || is_jalr || (is_load && ph);
        e.we       = is_store;
        e.pc_sel   = redirect ? 2'd1 : hold ? 2'd2 : 2'd0;
        e.inst_sel = redirect ? 2'd1 : hold ? 2'd2 : 2'd0;
        e.mem_sel  = is_store || hold;

        if (r) begin
            e.reg_wr   = 1'b0;
            e.we       = 1'b0;
            e.pc_sel   = 2'd0;
            e.inst_sel = 2'd1;
            e.mem_sel  = 1'b0;
        end
        return e;
    endfunction

    // Apply one instruction for one cycle, check outputs mid-cycle, then advance the model
    task automatic step(input logic [4:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic bb, input logic r);
        exp_t e;
        logic ph;
        opcode = op;
        func3  = f3;
        func7  = f7;
        b      = bb;
        rst    = r;
        ph     = load_run[0];
        e      = model(op, f3, f7, bb, r, ph);
        @(negedge clk);
        n_txn++;
        $display("txn %0d op=%b f3=%b f7=%b b=%b rst=%b phase=%0d alu=%b reg_wr=%b pc=%b inst=%b",
                 n_txn, op, f3, f7, bb, r, ph, alu_op, reg_wr, pc_sel, inst_sel);
        check("imm_type", 32'(imm_type), 32'(e.imm_type));
        check("inst_sel", 32'(inst_sel), 32'(e.inst_sel));
        check("reg_wr",   32'(reg_wr),   32'(e.reg_wr));
        check("alu_op",   32'(alu_op),   32'(e.alu_op));
        check("cmp_op",   32'(cmp_op),   32'(e.cmp_op));
        check("pc_sel",   32'(pc_sel),   32'(e.pc_sel));
        check("mem_sel",  32'(mem_sel),  32'(e.mem_sel));
        check("rd_sel",   32'(rd_sel),   32'(e.rd_sel));
        check("alu1_sel", 32'(alu1_sel), 32'(e.alu1_sel));
        check("alu2_sel", 32'(alu2_sel), 32'(e.alu2_sel));
        check("sel_type", 32'(sel_type), 32'(e.sel_type));
        check("we",       32'(we),       32'(e.we));
        @(posedge clk);
        if (r || op != 5'd0) load_run = 0;
        else                 load_run++;
        #1;
    endtask

    localparam logic [6:0] F7Z = 7'h00;
    localparam logic [6:0] F7A = 7'h20;

    initial begin
        logic [4:0] ops [9] = '{5'd0, 5'd4, 5'd5, 5'd8, 5'd12, 5'd13, 5'd24, 5'd25, 5'd27};
        logic [4:0] rop;
        logic [6:0] rf7;

        rst = 1'b1; opcode = 5'd0; func3 = 3'd0; func7 = F7Z; b = 1'b0;
        @(posedge clk); #1;

        step(5'd0,  3'd2, F7Z, 1'b0, 1'b1);   // reset with LOAD present
        step(5'd8,  3'd0, F7Z, 1'b1, 1'b1);   // reset with STORE present

        // ALU decode
        step(5'd12, 3'd0, F7A, 1'b0, 1'b0);
        step(5'd12, 3'd0, F7Z, 1'b0, 1'b0);
        step(5'd12, 3'd2, F7Z, 1'b0, 1'b0);
        step(5'd12, 3'd4, F7Z, 1'b0, 1'b0);
        step(5'd12, 3'd1, F7Z, 1'b0, 1'b0);
        step(5'd12, 3'd5, F7Z, 1'b0, 1'b0);
        step(5'd12, 3'd5, F7A, 1'b0, 1'b0);
        step(5'd8,  3'd0, F7A, 1'b0, 1'b0);
        step(5'd25, 3'd0, F7A, 1'b0, 1'b0);
        step(5'd4,  3'd0, F7A, 1'b0, 1'b0);
        step(5'd4,  3'd5, F7A, 1'b0, 1'b0);
        // immediates, operand selects, unknown opcode, branches
        step(5'd13, 3'd0, F7Z, 1'b0, 1'b0);
        step(5'd27, 3'd0, F7Z, 1'b0, 1'b0);
        step(5'd21, 3'd0, F7Z, 1'b0, 1'b0);
        step(5'd24, 3'd5, F7Z, 1'b0, 1'b0);
        step(5'd24, 3'd5, F7Z, 1'b1, 1'b0);
        // load sequence then store/op_imm interleave
        step(5'd0,  3'd4, F7Z, 1'b0, 1'b0);
        step(5'd0,  3'd4, F7Z, 1'b0, 1'b0);
        step(5'd4,  3'd0, F7Z, 1'b0, 1'b0);
        step(5'd8,  3'd1, F7Z, 1'b0, 1'b0);
        step(5'd4,  3'd0, F7Z, 1'b0, 1'b0);
        step(5'd8,  3'd1, F7Z, 1'b0, 1'b0);
        // three back-to-back LOADs: phases 0,1,0
        step(5'd0,  3'd0, F7Z, 1'b0, 1'b0);
        step(5'd0,  3'd0, F7Z, 1'b0, 1'b0);
        step(5'd0,  3'd0, F7Z, 1'b0, 1'b0);
        step(5'd4,  3'd0, F7Z, 1'b0, 1'b0);
        // reset asserted in LOAD phase 1: no write, next LOAD restarts at phase 0
        step(5'd0,  3'd2, F7Z, 1'b0, 1'b0);
        step(5'd0,  3'd2, F7Z, 1'b0, 1'b1);
        step(5'd0,  3'd2, F7Z, 1'b0, 1'b0);
        step(5'd0,  3'd2, F7Z, 1'b0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            rop = ($urandom_range(0, 4) == 0) ? 5'($urandom) : ops[$urandom_range(0, 8)];
            case ($urandom_range(0, 2))
                0:       rf7 = F7Z;
                1:       rf7 = F7A;
                default: rf7 = 7'($urandom);
            endcase
            step(rop, 3'($urandom), rf7, 1'($urandom), ($urandom_range(0, 19) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
